// File: rtl/dut_sweep_controller_if.sv
// ----------------------------------------------------------------------------
// dut_sweep_controller_if
//
// Purpose:
//   Bundles the signals around the sweep controller: the host command
//   handshake, the abort request, the drive/observe path to the
//   combinational dut, and the result handshake.
//
// Signal summary:
//   cmd_valid / cmd_ready       command handshake (host -> controller)
//   cmd_vector                  value applied to dut_input on accept
//   cmd_bit_count               number of bits to sample, from bit 0 up
//   abort                       cancel the sweep in progress
//   dut_input                   registered vector driven to the dut
//   dut_signal_select           registered bit index, zero-extended
//   dut_output                  selected dut result bit
//   result_valid / result_ready result handshake (controller -> consumer)
//   result_word                 bit i = dut_output sampled with select=i
//   result_bit_count            number of bits sampled
//   busy                        controller is not idle
//
// Modports:
//   master  the controller side (drives dut and results)
//   slave   the environment side (host, dut, result consumer)
// ----------------------------------------------------------------------------
interface dut_sweep_controller_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 6
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [DATA_WIDTH-1:0]  cmd_vector;
  logic [COUNT_WIDTH-1:0] cmd_bit_count;
  logic                   abort;
  logic [DATA_WIDTH-1:0]  dut_input;
  logic [DATA_WIDTH-1:0]  dut_signal_select;
  logic                   dut_output;
  logic                   result_valid;
  logic                   result_ready;
  logic [DATA_WIDTH-1:0]  result_word;
  logic [COUNT_WIDTH-1:0] result_bit_count;
  logic                   busy;

  modport master (
    input  cmd_valid, cmd_vector, cmd_bit_count, abort, dut_output, result_ready,
    output cmd_ready, dut_input, dut_signal_select, result_valid, result_word,
           result_bit_count, busy
  );

  modport slave (
    output cmd_valid, cmd_vector, cmd_bit_count, abort, dut_output, result_ready,
    input  cmd_ready, dut_input, dut_signal_select, result_valid, result_word,
           result_bit_count, busy
  );
endinterface

// File: rtl/dut_sweep_controller.sv
// ----------------------------------------------------------------------------
// dut_sweep_controller
//
// Purpose:
//   Sequences a combinational dut. On a command it applies the command vector
//   to dut_input, then steps dut_signal_select over bits 0..N-1. For each bit
//   it waits SETTLE_CYCLES cycles, then captures dut_output into the matching
//   bit of the result word. The finished word is offered over a valid/ready
//   handshake. An abort cancels the sweep and discards the result.
//
// Ports:
//   clk       single clock, all logic on the rising edge
//   reset     synchronous, active-high; overrides every other input
//   sweep_if  dut_sweep_controller_if.master (command, dut, result, busy)
//
// Parameters:
//   DATA_WIDTH     width of dut_input, dut_signal_select, result_word
//   COUNT_WIDTH    width of the bit-count fields; must hold DATA_WIDTH
//   SETTLE_CYCLES  wait cycles per bit before sampling, >= 1
// ----------------------------------------------------------------------------
module dut_sweep_controller #(
  parameter int DATA_WIDTH    = 32,
  parameter int COUNT_WIDTH   = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  dut_sweep_controller_if.master sweep_if
);

  // Settle counter only has to hold SETTLE_CYCLES-1.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]          SETTLE_RELOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT    = COUNT_WIDTH'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  dut_input_q, dut_input_d;
  logic [DATA_WIDTH-1:0]  result_word_q, result_word_d;
  logic [COUNT_WIDTH-1:0] select_q, select_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [SW-1:0]          settle_cnt_q, settle_cnt_d;
  logic [COUNT_WIDTH-1:0] eff_count;

  // A zero or oversized request means "sweep the whole word".
  always_comb begin
    eff_count = sweep_if.cmd_bit_count;
    if (sweep_if.cmd_bit_count == '0 || sweep_if.cmd_bit_count > FULL_COUNT) begin
      eff_count = FULL_COUNT;
    end
  end

  // Next-state logic. Abort is checked first in every non-idle state so it
  // beats a simultaneous result handshake and suppresses the pending sample.
  // The result word is cleared on accept, so each sample can simply OR its
  // bit into place; bits at or above N are therefore never set.
  always_comb begin
    state_d       = state_q;
    dut_input_d   = dut_input_q;
    result_word_d = result_word_q;
    select_d      = select_q;
    count_d       = count_q;
    settle_cnt_d  = settle_cnt_q;

    case (state_q)
      IDLE: begin
        if (sweep_if.cmd_valid) begin
          dut_input_d   = sweep_if.cmd_vector;
          count_d       = eff_count;
          select_d      = '0;
          result_word_d = '0;
          settle_cnt_d  = SETTLE_RELOAD;
          state_d       = SETTLE;
        end
      end
      SETTLE: begin
        if (sweep_if.abort) begin
          state_d = IDLE;
        end else if (settle_cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q - SW'(1);
        end
      end
      SAMPLE: begin
        if (sweep_if.abort) begin
          state_d = IDLE;
        end else begin
          result_word_d = result_word_q | (DATA_WIDTH'(sweep_if.dut_output) << select_q);
          if (select_q == count_q - COUNT_WIDTH'(1)) begin
            state_d = DONE;
          end else begin
            select_d     = select_q + COUNT_WIDTH'(1);
            settle_cnt_d = SETTLE_RELOAD;
            state_d      = SETTLE;
          end
        end
      end
      DONE: begin
        if (sweep_if.abort || sweep_if.result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      dut_input_q   <= '0;
      result_word_q <= '0;
      select_q      <= '0;
      count_q       <= '0;
      settle_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      dut_input_q   <= dut_input_d;
      result_word_q <= result_word_d;
      select_q      <= select_d;
      count_q       <= count_d;
      settle_cnt_q  <= settle_cnt_d;
    end
  end

  // Status outputs decode straight from the registered state.
  assign sweep_if.cmd_ready         = (state_q == IDLE);
  assign sweep_if.busy              = (state_q != IDLE);
  assign sweep_if.result_valid      = (state_q == DONE);
  assign sweep_if.dut_input         = dut_input_q;
  assign sweep_if.dut_signal_select = DATA_WIDTH'(select_q);
  assign sweep_if.result_word       = result_word_q;
  assign sweep_if.result_bit_count  = count_q;

endmodule

// File: tb/tb_dut_sweep_controller.sv
// ----------------------------------------------------------------------------
// tb_dut_sweep_controller
//
// Purpose:
//   Self-checking bench for dut_sweep_controller. A small combinational dut
//   returns bit [select] of input[31:16]+input[15:0]. Expected result words,
//   bit counts and latencies come from a reference model that works on the
//   whole sum at once. Inputs are driven and outputs sampled on the falling
//   edge.
// ----------------------------------------------------------------------------
module tb_dut_sweep_controller;

  localparam int DW     = 32;
  localparam int CW     = 6;
  localparam int SETTLE = 2;
  localparam int BUDGET = 300;

  logic clk = 1'b0;
  logic reset;
  int   numVectors = 0;
  int   numMiscompares = 0;

  dut_sweep_controller_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) sweepIf ();

  dut_sweep_controller #(
    .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sweep_if (sweepIf.master)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // The combinational dut being swept: one bit of a 17-bit sum.
  logic [16:0] dutSum;
  assign dutSum = {1'b0, sweepIf.dut_input[31:16]} + {1'b0, sweepIf.dut_input[15:0]};
  assign sweepIf.dut_output = (sweepIf.dut_signal_select < 32'd17) ?
                              dutSum[sweepIf.dut_signal_select[4:0]] : 1'b0;

  // Reference model: effective count, masked sum, and cycles to result_valid.
  function automatic int effN(input int c);
    return (c == 0 || c > DW) ? DW : c;
  endfunction

  function automatic logic [31:0] expWord(input logic [31:0] v, input int c);
    logic [31:0] s;
    int n;
    n = effN(c);
    s = 32'(v[31:16]) + 32'(v[15:0]);
    if (n < 32) s = s & ((32'h1 << n) - 32'h1);
    return s;
  endfunction

  function automatic int expLatency(input int c);
    return effN(c) * (SETTLE + 1);
  endfunction

  // Drives one command; returns on the falling edge after the accepting edge.
  task automatic applyStimulus(input logic [31:0] vec, input int cnt);
    int waited = 0;
    while (!sweepIf.cmd_ready && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    if (!sweepIf.cmd_ready) begin
      numVectors++;
      numMiscompares++;
      $display("[TB] FAIL cmd_accept: cmd_ready=0 after %0d cycles, required 1", waited);
    end
    sweepIf.cmd_vector    = vec;
    sweepIf.cmd_bit_count = CW'(cnt);
    sweepIf.cmd_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sweepIf.cmd_valid = 1'b0;
    sweepIf.abort     = 1'b0;
  endtask

  // Counts falling edges until result_valid; -1 if it never rises.
  task automatic waitResult(output int cycles);
    cycles = -1;
    for (int j = 1; j <= BUDGET; j++) begin
      @(negedge clk);
      if (sweepIf.result_valid) begin
        cycles = j;
        break;
      end
    end
  endtask

  // Completes the result handshake with result_ready for one edge.
  task automatic consumeResult();
    sweepIf.result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sweepIf.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    numVectors++;
    if (sweepIf.cmd_ready !== 1'b1) begin
      numMiscompares++;
      $display("[TB] FAIL reset_cmd_ready: got %b expected 1", sweepIf.cmd_ready);
    end
    numVectors++;
    if ({sweepIf.busy, sweepIf.result_valid} !== 2'b00) begin
      numMiscompares++;
      $display("[TB] FAIL reset_busy_valid: got %b expected 00", {sweepIf.busy, sweepIf.result_valid});
    end
    numVectors++;
    if ({sweepIf.dut_input, sweepIf.dut_signal_select, sweepIf.result_word} !== 96'h0) begin
      numMiscompares++;
      $display("[TB] FAIL reset_data: got %h/%h/%h expected all 0",
               sweepIf.dut_input, sweepIf.dut_signal_select, sweepIf.result_word);
    end
    numVectors++;
    if (sweepIf.result_bit_count !== 6'd0) begin
      numMiscompares++;
      $display("[TB] FAIL reset_count: got %0d expected 0", sweepIf.result_bit_count);
    end
  endtask

  task automatic test_full_sweep();
    int lat;
    applyStimulus(32'h0003_0005, 32);
    numVectors++;
    if ({sweepIf.busy, sweepIf.cmd_ready} !== 2'b10) begin
      numMiscompares++;
      $display("[TB] FAIL full_busy: got busy,ready=%b expected 10", {sweepIf.busy, sweepIf.cmd_ready});
    end
    numVectors++;
    if (sweepIf.dut_input !== 32'h0003_0005 || sweepIf.dut_signal_select !== 32'd0) begin
      numMiscompares++;
      $display("[TB] FAIL full_drive: got input %h select %0d expected 00030005 / 0",
               sweepIf.dut_input, sweepIf.dut_signal_select);
    end
    waitResult(lat);
    numVectors++;
    if (lat !== 96) begin
      numMiscompares++;
      $display("[TB] FAIL full_latency: got %0d expected 96", lat);
    end
    numVectors++;
    if (sweepIf.result_word !== 32'h0000_0008 || sweepIf.result_bit_count !== 6'd32) begin
      numMiscompares++;
      $display("[TB] FAIL full_result: got %h/%0d expected 00000008/32",
               sweepIf.result_word, sweepIf.result_bit_count);
    end
    consumeResult();
    numVectors++;
    if ({sweepIf.result_valid, sweepIf.cmd_ready} !== 2'b01) begin
      numMiscompares++;
      $display("[TB] FAIL full_handshake: got valid,ready=%b expected 01",
               {sweepIf.result_valid, sweepIf.cmd_ready});
    end
  endtask

  task automatic test_partial_count();
    int lat;
    applyStimulus(32'hFFFF_0001, 17);
    waitResult(lat);
    numVectors++;
    if (lat !== 51) begin
      numMiscompares++;
      $display("[TB] FAIL partial_latency: got %0d expected 51", lat);
    end
    numVectors++;
    if (sweepIf.result_word !== 32'h0001_0000 || sweepIf.result_bit_count !== 6'd17) begin
      numMiscompares++;
      $display("[TB] FAIL partial_result: got %h/%0d expected 00010000/17",
               sweepIf.result_word, sweepIf.result_bit_count);
    end
    consumeResult();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] vec = $urandom;
    logic [31:0] want = expWord(vec, 5);
    applyStimulus(vec, 5);
    waitResult(lat);
    numVectors++;
    if (lat !== expLatency(5)) begin
      numMiscompares++;
      $display("[TB] FAIL bp_latency: got %0d expected %0d", lat, expLatency(5));
    end
    for (int i = 0; i < 10; i++) begin
      sweepIf.cmd_valid  = (i == 3);
      sweepIf.cmd_vector = ~vec;
      @(negedge clk);
      numVectors++;
      if ({sweepIf.result_valid, sweepIf.cmd_ready} !== 2'b10 || sweepIf.result_word !== want) begin
        numMiscompares++;
        $display("[TB] FAIL bp_hold[%0d]: got valid,ready=%b word %h expected 10 / %h",
                 i, {sweepIf.result_valid, sweepIf.cmd_ready}, sweepIf.result_word, want);
      end
    end
    sweepIf.cmd_valid = 1'b0;
    consumeResult();
    numVectors++;
    if (sweepIf.dut_input !== vec || sweepIf.result_valid !== 1'b0) begin
      numMiscompares++;
      $display("[TB] FAIL bp_no_accept: got input %h valid %b expected %h / 0",
               sweepIf.dut_input, sweepIf.result_valid, vec);
    end
  endtask

  task automatic test_abort();
    int lat;
    int waited = 0;
    bit sawValid = 1'b0;
    logic [31:0] vec = $urandom;
    applyStimulus(vec, 32);
    while (sweepIf.dut_signal_select !== 32'd5 && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    sweepIf.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sweepIf.abort = 1'b0;
    numVectors++;
    if ({sweepIf.cmd_ready, sweepIf.busy, sweepIf.result_valid} !== 3'b100) begin
      numMiscompares++;
      $display("[TB] FAIL abort_idle: got ready,busy,valid=%b expected 100",
               {sweepIf.cmd_ready, sweepIf.busy, sweepIf.result_valid});
    end
    numVectors++;
    if (sweepIf.result_word !== expWord(vec, 5) || sweepIf.dut_input !== vec) begin
      numMiscompares++;
      $display("[TB] FAIL abort_kept: got word %h input %h expected %h / %h",
               sweepIf.result_word, sweepIf.dut_input, expWord(vec, 5), vec);
    end
    repeat (60) begin
      @(negedge clk);
      if (sweepIf.result_valid) sawValid = 1'b1;
    end
    numVectors++;
    if (sawValid !== 1'b0) begin
      numMiscompares++;
      $display("[TB] FAIL abort_no_result: got result_valid seen=%b expected 0", sawValid);
    end
    // Abort held during the accepting cycle is ignored in IDLE.
    sweepIf.abort = 1'b1;
    applyStimulus(32'h0001_0001, 4);
    waitResult(lat);
    numVectors++;
    if (lat !== 12 || sweepIf.result_word !== 32'h0000_0002) begin
      numMiscompares++;
      $display("[TB] FAIL abort_next_cmd: got latency %0d word %h expected 12 / 00000002",
               lat, sweepIf.result_word);
    end
    // Abort together with result_ready in DONE still just returns to IDLE.
    sweepIf.abort = 1'b1;
    consumeResult();
    sweepIf.abort = 1'b0;
    numVectors++;
    if ({sweepIf.cmd_ready, sweepIf.result_valid} !== 2'b10) begin
      numMiscompares++;
      $display("[TB] FAIL abort_done: got ready,valid=%b expected 10",
               {sweepIf.cmd_ready, sweepIf.result_valid});
    end
  endtask

  task automatic test_count_clamp();
    int lat;
    int counts[2] = '{0, 40};
    foreach (counts[k]) begin
      applyStimulus(32'h8000_8000, counts[k]);
      waitResult(lat);
      numVectors++;
      if (lat !== 96 || sweepIf.result_word !== 32'h0001_0000 || sweepIf.result_bit_count !== 6'd32) begin
        numMiscompares++;
        $display("[TB] FAIL clamp_count%0d: got latency %0d word %h count %0d expected 96 / 00010000 / 32",
                 counts[k], lat, sweepIf.result_word, sweepIf.result_bit_count);
      end
      consumeResult();
    end
  endtask

  task automatic test_reset_midsweep();
    int lat;
    applyStimulus(32'h1234_5678, 32);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    numVectors++;
    if ({sweepIf.dut_input, sweepIf.dut_signal_select, sweepIf.result_word} !== 96'h0 ||
        sweepIf.result_bit_count !== 6'd0 ||
        {sweepIf.cmd_ready, sweepIf.busy, sweepIf.result_valid} !== 3'b100) begin
      numMiscompares++;
      $display("[TB] FAIL midreset_outputs: got %h/%h/%h cnt %0d ready,busy,valid=%b expected 0s, 100",
               sweepIf.dut_input, sweepIf.dut_signal_select, sweepIf.result_word,
               sweepIf.result_bit_count, {sweepIf.cmd_ready, sweepIf.busy, sweepIf.result_valid});
    end
    reset = 1'b0;
    applyStimulus(32'h0003_0005, 8);
    waitResult(lat);
    numVectors++;
    if (lat !== 24 || sweepIf.result_word !== 32'h0000_0008) begin
      numMiscompares++;
      $display("[TB] FAIL midreset_rerun: got latency %0d word %h expected 24 / 00000008",
               lat, sweepIf.result_word);
    end
    consumeResult();
  endtask

  task automatic test_random();
    int lat;
    int cnt;
    logic [31:0] vec;
    for (int t = 0; t < 15; t++) begin
      vec = $urandom;
      cnt = $urandom_range(0, 40);
      applyStimulus(vec, cnt);
      waitResult(lat);
      numVectors++;
      if (lat !== expLatency(cnt)) begin
        numMiscompares++;
        $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", t, lat, expLatency(cnt));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      numVectors++;
      if (sweepIf.result_word !== expWord(vec, cnt) || sweepIf.result_bit_count !== CW'(effN(cnt))) begin
        numMiscompares++;
        $display("[TB] FAIL rand_result[%0d]: vec %h cnt %0d got %h/%0d expected %h/%0d", t, vec, cnt,
                 sweepIf.result_word, sweepIf.result_bit_count, expWord(vec, cnt), effN(cnt));
      end
      consumeResult();
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    reset                 = 1'b1;
    sweepIf.cmd_valid     = 1'b0;
    sweepIf.cmd_vector    = '0;
    sweepIf.cmd_bit_count = '0;
    sweepIf.abort         = 1'b0;
    sweepIf.result_ready  = 1'b0;
    test_reset();
    test_full_sweep();
    test_partial_count();
    test_backpressure();
    test_abort();
    test_count_clamp();
    test_reset_midsweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
